// File: rtl/seven_seg_scan_ctrl_if.sv
// Update channel from game logic into the seven-segment scan controller.
// The master offers display contents; the slave (controller) accepts them.
interface seven_seg_scan_ctrl_if #(
   parameter int w_digit = 4
);
   logic                   upd_valid;
   logic                   upd_ready;
   logic [4*w_digit-1:0]   upd_values;
   logic [w_digit-1:0]     upd_blank;
   logic [w_digit-1:0]     upd_blink;
   logic                   upd_lz;

   modport master (
      output upd_valid, upd_values, upd_blank, upd_blink, upd_lz,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_values, upd_blank, upd_blink, upd_lz,
      output upd_ready
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Rate-controlled seven-segment scan with double-buffered updates that commit
// on frame boundaries, plus per-digit blanking, blinking and leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int clk_mhz      = 50,
   parameter int w_digit      = 4,
   parameter int digit_period = 50000,
   parameter int blink_frames = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   seven_seg_scan_ctrl_if.slave upd,
   output logic [7:0]           abcdefgh,
   output logic [w_digit-1:0]   digit,
   output logic                 frame_done
);

   localparam int tw = $clog2(digit_period);
   localparam int iw = $clog2(w_digit);
   localparam int fw = (blink_frames > 1) ? $clog2(blink_frames) : 1;
   localparam logic [tw-1:0] tick_max  = tw'(digit_period - 1);
   localparam logic [iw-1:0] idx_max   = iw'(w_digit - 1);
   localparam logic [fw-1:0] frame_max = fw'(blink_frames - 1);

   if (clk_mhz < 1 || w_digit < 2 || w_digit > 8 || digit_period < 2 || blink_frames < 1) begin : g_bad_param
      $error("seven_seg_scan_ctrl: parameter out of range");
   end

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 8'hFC;
         4'h1:    hex_to_seg = 8'h60;
         4'h2:    hex_to_seg = 8'hDA;
         4'h3:    hex_to_seg = 8'hF2;
         4'h4:    hex_to_seg = 8'h66;
         4'h5:    hex_to_seg = 8'hB6;
         4'h6:    hex_to_seg = 8'hBE;
         4'h7:    hex_to_seg = 8'hE0;
         4'h8:    hex_to_seg = 8'hFE;
         4'h9:    hex_to_seg = 8'hF6;
         4'hA:    hex_to_seg = 8'hEE;
         4'hB:    hex_to_seg = 8'h3E;
         4'hC:    hex_to_seg = 8'h9C;
         4'hD:    hex_to_seg = 8'h7A;
         4'hE:    hex_to_seg = 8'h9E;
         4'hF:    hex_to_seg = 8'h8E;
         default: hex_to_seg = 8'h00;
      endcase
   endfunction

   logic [tw-1:0]          tick_cnt_r, tick_cnt_s;
   logic [iw-1:0]          idx_r, idx_s;
   logic [fw-1:0]          frame_cnt_r, frame_cnt_s;
   logic                   phase_r, phase_s;
   logic                   pending_r, pending_s;
   logic                   ready_r;
   logic [4*w_digit-1:0]   pend_values_r, act_values_r, act_values_s;
   logic [w_digit-1:0]     pend_blank_r, act_blank_r, act_blank_s;
   logic [w_digit-1:0]     pend_blink_r, act_blink_r, act_blink_s;
   logic                   pend_lz_r, act_lz_r, act_lz_s;
   logic                   tick_s, wrap_s, xfer_s, commit_s;
   logic                   zero_run_s;
   logic [w_digit-1:0]     hidden_s;
   logic [3:0]             nib_s;
   logic [7:0]             seg_s;
   logic [w_digit-1:0]     digit_s;

   assign upd.upd_ready = ready_r;

   // Next-state of the scan, blink and buffer registers; outputs are encoded
   // from these next values so the registered display matches the new state.
   always_comb begin
      tick_s   = (tick_cnt_r == tick_max);
      wrap_s   = tick_s && (idx_r == idx_max);
      xfer_s   = upd.upd_valid && ready_r;
      commit_s = wrap_s && pending_r;

      if (tick_s) begin
         tick_cnt_s = '0;
         if (wrap_s) begin
            idx_s = '0;
         end else begin
            idx_s = idx_r + iw'(1);
         end
      end else begin
         tick_cnt_s = tick_cnt_r + tw'(1);
         idx_s      = idx_r;
      end

      if (wrap_s && (frame_cnt_r == frame_max)) begin
         frame_cnt_s = '0;
         phase_s     = ~phase_r;
      end else if (wrap_s) begin
         frame_cnt_s = frame_cnt_r + fw'(1);
         phase_s     = phase_r;
      end else begin
         frame_cnt_s = frame_cnt_r;
         phase_s     = phase_r;
      end

      if (commit_s) begin
         act_values_s = pend_values_r;
         act_blank_s  = pend_blank_r;
         act_blink_s  = pend_blink_r;
         act_lz_s     = pend_lz_r;
      end else begin
         act_values_s = act_values_r;
         act_blank_s  = act_blank_r;
         act_blink_s  = act_blink_r;
         act_lz_s     = act_lz_r;
      end

      if (xfer_s) begin
         pending_s = 1'b1;
      end else if (commit_s) begin
         pending_s = 1'b0;
      end else begin
         pending_s = pending_r;
      end

      // zero_run tracks "this nibble and every higher one are zero"
      zero_run_s = 1'b1;
      hidden_s   = '0;
      for (int i = w_digit - 1; i >= 0; i--) begin
         zero_run_s  = zero_run_s && (act_values_s[4*i +: 4] == 4'h0);
         hidden_s[i] = act_blank_s[i] || (act_blink_s[i] && phase_s) ||
                       (act_lz_s && (i != 0) && zero_run_s);
      end

      nib_s   = act_values_s[{idx_s, 2'b00} +: 4];
      seg_s   = hidden_s[idx_s] ? 8'h00 : hex_to_seg(nib_s);
      digit_s = {{(w_digit-1){1'b0}}, 1'b1} << idx_s;
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r    <= '0;
         idx_r         <= '0;
         frame_cnt_r   <= '0;
         phase_r       <= 1'b0;
         pending_r     <= 1'b0;
         ready_r       <= 1'b1;
         pend_values_r <= '0;
         pend_blank_r  <= '0;
         pend_blink_r  <= '0;
         pend_lz_r     <= 1'b0;
         act_values_r  <= '0;
         act_blank_r   <= '1;
         act_blink_r   <= '0;
         act_lz_r      <= 1'b0;
         abcdefgh      <= 8'h00;
         digit         <= {{(w_digit-1){1'b0}}, 1'b1};
         frame_done    <= 1'b0;
      end else begin
         tick_cnt_r   <= tick_cnt_s;
         idx_r        <= idx_s;
         frame_cnt_r  <= frame_cnt_s;
         phase_r      <= phase_s;
         pending_r    <= pending_s;
         ready_r      <= ~pending_s;
         act_values_r <= act_values_s;
         act_blank_r  <= act_blank_s;
         act_blink_r  <= act_blink_s;
         act_lz_r     <= act_lz_s;
         if (xfer_s) begin
            pend_values_r <= upd.upd_values;
            pend_blank_r  <= upd.upd_blank;
            pend_blink_r  <= upd.upd_blink;
            pend_lz_r     <= upd.upd_lz;
         end
         abcdefgh   <= seg_s;
         digit      <= digit_s;
         frame_done <= wrap_s;
      end
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing controller for the board's dynamic seven-segment display. It replaces the free-running per-clock digit rotation with a rate-controlled scan. It accepts new display contents from game logic through a valid/ready handshake, double-buffers them so updates land only on frame boundaries, and applies per-digit blanking, blinking and leading-zero suppression. It sits between the game core (score, lives, debug fields) and the board's abcdefgh/digit pins.

Parameters:
clk_mhz, 50, system clock in MHz; documentation only, not used in arithmetic.
w_digit, 4, number of digit positions scanned (2..8).
digit_period, 50000, clock cycles each digit stays lit. Must be >= 2; benches override it to a small value.
blink_frames, 64, full scan frames per blink half-period.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
upd_valid  input  1  new display contents offered
upd_ready  output  1  controller can accept an update
upd_values  input  4*w_digit  hex nibble per digit; nibble i (bits 4i+3:4i) drives digit i
upd_blank  input  w_digit  per-digit force-blank mask
upd_blink  input  w_digit  per-digit blink enable
upd_lz  input  1  leading-zero suppression enable
abcdefgh  output  8  segment drive, active-high; bit7 = a, bit0 = h (dp)
digit  output  w_digit  one-hot digit enable, active-high; bit i selects digit i
frame_done  output  1  one-cycle pulse when the scan wraps from digit w_digit-1 to digit 0

Behaviour:
- Reset (synchronous, rst=1 at posedge) sets:
  - tick counter = 0, scan index = 0, blink frame counter = 0, blink phase = 0.
  - pending flag = 0; any pending update is discarded.
  - active values = 0, active blank = all ones, active blink = 0, active lz = 0.
  - digit = one-hot digit 0 (only bit 0 set), abcdefgh = 8'h00, upd_ready = 1, frame_done = 0.
- Tick counter:
  - Counts 0..digit_period-1 and wraps.
  - tick = (counter == digit_period-1).
- Scan index:
  - Advances on tick and wraps from w_digit-1 to 0.
  - wrap = tick && index == w_digit-1.
- Outputs are registered:
  - digit and abcdefgh update together in the cycle after tick, from the new index and the active registers.
  - abcdefgh is also refreshed every cycle for the current index, so a commit is visible on the next cycle.
  - frame_done = 1 in the cycle after wrap only.
- Handshake:
  - Transfer occurs when upd_valid && upd_ready.
  - On transfer, all upd_* inputs are captured into pending registers, pending=1, and upd_ready=0 from the next cycle.
  - upd_ready = !pending (registered).
  - Inputs are ignored when not ready.
- Commit:
  - On wrap with pending=1, the pending registers are copied into the active registers and pending is cleared; upd_ready returns to 1 on the next cycle.
  - A transfer in the same cycle as wrap fills pending and commits at the following wrap, not this one.
- Blink:
  - The frame counter increments on wrap.
  - When it reaches blink_frames-1, it clears and blink phase toggles.
- Digit visibility, evaluated for index i:
  - Shown unless active blank[i]=1.
  - Hidden if blink[i]=1 and blink phase = 1.
  - Hidden by leading-zero suppression when active lz=1, i != 0, and value nibbles i..w_digit-1 are all 0.
  - Digit 0 is never hidden by leading-zero suppression.
  - A hidden digit drives abcdefgh = 8'h00; digit still strobes.
- Hex encoding (dp always 0):
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
- rst asserted mid-frame or mid-handshake:
  - Same as power-on reset.
  - Scanning restarts at digit 0 with a full digit_period.

Test Plan:
1. Scan timing (digit_period=4, w_digit=4): after rst release, digit cycles 0001 -> 0010 -> 0100 -> 1000 -> 0001, each value held 4 cycles. frame_done pulses once per 16 cycles, in the cycle digit returns to 0001.
2. Handshake and commit: pulse upd_valid with upd_values=16'h4321, blank=0. Expect upd_ready=0 next cycle; abcdefgh stays 00 until the next wrap. From the next frame, expect 60/DA/F2/66 on digits 0..3, and upd_ready back to 1 after the commit.
3. Back-pressure: offer a second update (16'h0000) while pending. It is ignored; digits still show 4321 after the commit, and upd_ready stays 0 while the valid is held.
4. Same-cycle transfer at wrap: assert valid exactly on the wrap cycle. The commit is deferred one full frame (16 cycles at the test parameters).
5. Leading zeros: values=16'h0050, lz=1 gives digit3=00, digit2=00, digit1=B6, digit0=FC. values=16'h0000, lz=1 gives only digit0=FC.
6. Blink and reset: blink=4'b0001, blink_frames=2. digit0 alternates FC/00 every 2 frames. Asserting rst mid-frame returns digit=0001, abcdefgh=00 and upd_ready=1 on the next cycle.
